// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: two debounced keys drive an IDLE/RUN/LAP/STOP FSM
// that controls the BCD counter and picks live or lap-frozen display time.
module sw_key_debounce #(
    parameter int unsigned DEB_CYCLES = 20'd500000,
    parameter int          CNT_W      = 20
) (
    input  logic clk,
    input  logic clr,
    input  logic key,
    output logic press
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= key;
            sync_b  <= sync_a;
            level_d <= level;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Rising edge of the accepted level only; releases and holds are silent.
    assign press = level & ~level_d;

endmodule

module stopwatch_ctrl #(
    parameter int unsigned DEB_CYCLES = 20'd500000,
    parameter int          CNT_W      = 20
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        key_ss,
    input  logic        key_lr,
    input  logic [23:0] time_in,
    output logic        timer_clr,
    output logic        timer_pause,
    output logic [23:0] disp,
    output logic [3:0]  lap_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LAP  = 2'b10,
        STOP = 2'b11
    } state_t;

    logic        ss_press;
    logic        lr_press;
    state_t      cur;
    logic [23:0] lap_time;
    logic [3:0]  laps;
    logic        clr_q;
    logic        pause_q;

    sw_key_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_deb_ss (
        .clk  (clk),
        .clr  (clr),
        .key  (key_ss),
        .press(ss_press)
    );

    sw_key_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_deb_lr (
        .clk  (clk),
        .clr  (clr),
        .key  (key_lr),
        .press(lr_press)
    );

    // Start/stop wins over a coincident lap/reset press, which is dropped.
    always_ff @(posedge clk) begin
        if (clr) begin
            cur      <= IDLE;
            clr_q    <= 1'b1;
            pause_q  <= 1'b1;
            laps     <= 4'd0;
            lap_time <= 24'd0;
        end else begin
            unique case (cur)
                IDLE: begin
                    if (ss_press) begin
                        cur     <= RUN;
                        clr_q   <= 1'b0;
                        pause_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (ss_press) begin
                        cur     <= STOP;
                        pause_q <= 1'b1;
                    end else if (lr_press) begin
                        cur      <= LAP;
                        lap_time <= time_in;
                        laps     <= laps + 4'd1;
                    end
                end
                LAP: begin
                    if (ss_press) begin
                        cur     <= STOP;
                        pause_q <= 1'b1;
                    end else if (lr_press) begin
                        cur <= RUN;
                    end
                end
                STOP: begin
                    if (ss_press) begin
                        cur     <= RUN;
                        pause_q <= 1'b0;
                    end else if (lr_press) begin
                        cur      <= IDLE;
                        clr_q    <= 1'b1;
                        laps     <= 4'd0;
                        lap_time <= 24'd0;
                    end
                end
            endcase
        end
    end

    assign state       = cur;
    assign timer_clr   = clr_q;
    assign timer_pause = pause_q;
    assign lap_cnt     = laps;
    assign disp        = (cur == LAP) ? lap_time : time_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, corner sequences and random keys,
// every cycle compared against a sample-window reference model.
module tb_stopwatch_ctrl;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        key_ss;
    logic        key_lr;
    logic [23:0] time_in;
    logic        timer_clr;
    logic        timer_pause;
    logic [23:0] disp;
    logic [3:0]  lap_cnt;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;

    stopwatch_ctrl #(.DEB_CYCLES(DEB)) dut (
        .clk        (clk),
        .clr        (clr),
        .key_ss     (key_ss),
        .key_lr     (key_lr),
        .time_in    (time_in),
        .timer_clr  (timer_clr),
        .timer_pause(timer_pause),
        .disp       (disp),
        .lap_cnt    (lap_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Reference model: a key level is accepted once the last DEB synchronized
    // samples all disagree with the current accepted level.
    logic [1:0]     m_r1, m_r2, m_deb, m_pend;
    logic [DEB-1:0] m_win [2];
    int             m_wn [2];
    int             m_state;
    logic [23:0]    m_lap;
    int             m_laps;
    int             nxt_ss [4] = '{1, 3, 3, 1};
    int             nxt_lr [4] = '{0, 2, 1, 0};

    initial begin
        m_r1 = '0; m_r2 = '0; m_deb = '0; m_pend = '0;
        m_win[0] = '0; m_win[1] = '0; m_wn[0] = 0; m_wn[1] = 0;
        m_state = 0; m_lap = '0; m_laps = 0;
    end

    always @(posedge clk) begin
        logic [1:0] raw;
        logic       syn;
        raw = {key_lr, key_ss};
        if (clr) begin
            m_r1 = '0; m_r2 = '0; m_deb = '0; m_pend = '0;
            m_win[0] = '0; m_win[1] = '0; m_wn[0] = 0; m_wn[1] = 0;
            m_state = 0; m_lap = '0; m_laps = 0;
        end else begin
            if (m_pend[0]) begin
                m_state = nxt_ss[m_state];
            end else if (m_pend[1]) begin
                if (m_state == 1) begin
                    m_lap  = time_in;
                    m_laps = (m_laps + 1) % 16;
                end
                if (m_state == 3) begin
                    m_lap  = '0;
                    m_laps = 0;
                end
                m_state = nxt_lr[m_state];
            end
            for (int k = 0; k < 2; k++) begin
                syn      = m_r2[k];
                m_r2[k]  = m_r1[k];
                m_r1[k]  = raw[k];
                m_win[k] = {m_win[k][DEB-2:0], syn};
                if (m_wn[k] < DEB) m_wn[k]++;
                m_pend[k] = 1'b0;
                if (m_wn[k] == DEB && m_win[k] == {DEB{~m_deb[k]}}) begin
                    m_deb[k]  = ~m_deb[k];
                    m_pend[k] = m_deb[k];
                end
            end
        end
    end

    task automatic cmp(string nm, logic [23:0] act, logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        cmp({tag, " state"}, 24'(state), 24'(m_state));
        cmp({tag, " timer_clr"}, 24'(timer_clr), 24'(m_state == 0));
        cmp({tag, " timer_pause"}, 24'(timer_pause),
            24'(m_state == 0 || m_state == 3));
        cmp({tag, " lap_cnt"}, 24'(lap_cnt), 24'(m_laps));
        cmp({tag, " disp"}, disp, (m_state == 2) ? m_lap : time_in);
    endtask

    task automatic step(logic r, logic ss, logic lr, logic [23:0] t, int n,
                        string tag);
        for (int c = 0; c < n; c++) begin
            clr = r; key_ss = ss; key_lr = lr; time_in = t;
            @(negedge clk);
            check_model(tag);
        end
    endtask

    task automatic expect_st(string tag, logic [1:0] st, logic [3:0] lc);
        cmp({tag, " exp_state"}, 24'(state), 24'(st));
        cmp({tag, " exp_laps"}, 24'(lap_cnt), 24'(lc));
    endtask

    typedef struct {
        logic        rst;
        logic        ss;
        logic        lr;
        logic [23:0] tin;
        int          n;
        logic [1:0]  st;
        logic [3:0]  laps;
        logic [23:0] dsp;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(logic rst, logic ss, logic lr, logic [23:0] tin,
                              int n, logic [1:0] st, logic [3:0] laps,
                              logic [23:0] dsp);
        vec_t e;
        e.rst = rst; e.ss = ss; e.lr = lr; e.tin = tin; e.n = n;
        e.st = st; e.laps = laps; e.dsp = dsp;
        tbl.push_back(e);
    endfunction

    localparam logic [23:0] TA = 24'h000111;
    localparam logic [23:0] TB = 24'h054321;
    localparam logic [23:0] TC = 24'h000777;

    initial begin
        clr = 1'b1; key_ss = 1'b0; key_lr = 1'b0; time_in = TA;

        v(1, 0, 0, TA, 1, 2'b00, 0, TA);
        v(0, 1, 0, TA, 3, 2'b00, 0, TA);
        v(0, 0, 0, TA, 8, 2'b00, 0, TA);
        v(0, 1, 0, TA, 6, 2'b00, 0, TA);
        v(0, 1, 0, TA, 1, 2'b01, 0, TA);
        v(0, 1, 0, TA, 10, 2'b01, 0, TA);
        v(0, 0, 0, TA, 8, 2'b01, 0, TA);
        v(0, 0, 1, 24'h012345, 8, 2'b10, 1, 24'h012345);
        v(0, 0, 0, 24'h012345, 8, 2'b10, 1, 24'h012345);
        v(0, 0, 0, 24'h012399, 1, 2'b10, 1, 24'h012345);
        v(0, 0, 1, 24'h012399, 8, 2'b01, 1, 24'h012399);
        v(0, 0, 0, 24'h012399, 8, 2'b01, 1, 24'h012399);
        v(0, 1, 0, TA, 8, 2'b11, 1, TA);
        v(0, 0, 0, TA, 8, 2'b11, 1, TA);
        v(0, 0, 1, TA, 8, 2'b00, 0, TA);
        v(0, 0, 0, TA, 8, 2'b00, 0, TA);
        v(0, 0, 1, TA, 8, 2'b00, 0, TA);
        v(0, 0, 0, TA, 8, 2'b00, 0, TA);
        v(0, 1, 0, TA, 8, 2'b01, 0, TA);
        v(0, 0, 0, TA, 8, 2'b01, 0, TA);
        v(0, 0, 1, TB, 8, 2'b10, 1, TB);
        v(0, 0, 0, TA, 8, 2'b10, 1, TB);
        v(0, 0, 1, TA, 8, 2'b01, 1, TA);
        v(0, 0, 0, TA, 8, 2'b01, 1, TA);
        v(0, 1, 1, TC, 8, 2'b11, 1, TC);
        v(0, 0, 0, TC, 8, 2'b11, 1, TC);
        v(0, 0, 1, TC, 8, 2'b00, 0, TC);
        v(0, 0, 0, TC, 8, 2'b00, 0, TC);
        v(0, 1, 0, TA, 8, 2'b01, 0, TA);
        v(0, 0, 0, TA, 8, 2'b01, 0, TA);

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].rst, tbl[i].ss, tbl[i].lr, tbl[i].tin, tbl[i].n, tag);
            expect_st(tag, tbl[i].st, tbl[i].laps);
            cmp({tag, " exp_disp"}, disp, tbl[i].dsp);
            cmp({tag, " exp_tclr"}, 24'(timer_clr), 24'(tbl[i].st == 2'b00));
            cmp({tag, " exp_tpause"}, 24'(timer_pause),
                24'(tbl[i].st == 2'b00 || tbl[i].st == 2'b11));
        end

        // Sixteen laps: lap_cnt walks up to 15 and wraps to 0.
        for (int i = 1; i <= 16; i++) begin
            logic [23:0] t;
            t = 24'(i * 24'h000101);
            step(0, 0, 1, t, 8, "wrap_lap");
            step(0, 0, 0, t, 8, "wrap_lap");
            expect_st($sformatf("wrap%0d_lap", i), 2'b10, 4'(i % 16));
            cmp($sformatf("wrap%0d_disp", i), disp, t);
            if (i < 16) begin
                step(0, 0, 1, TA, 8, "wrap_run");
                step(0, 0, 0, TA, 8, "wrap_run");
                expect_st($sformatf("wrap%0d_run", i), 2'b01, 4'(i % 16));
            end
        end

        // clr lands on the same edge as an ss press pulse while in LAP.
        step(0, 1, 0, TA, 6, "midclr_pre");
        expect_st("midclr_pre", 2'b10, 0);
        step(1, 1, 0, TA, 1, "midclr");
        expect_st("midclr", 2'b00, 0);
        cmp("midclr_disp", disp, TA);
        // ss held through clr release is re-debounced from scratch.
        step(0, 1, 0, TA, 6, "held_wait");
        expect_st("held_wait", 2'b00, 0);
        step(0, 1, 0, TA, 1, "held_press");
        expect_st("held_press", 2'b01, 0);
        step(0, 0, 0, TA, 8, "held_rel");

        for (int s = 0; s < 400; s++) begin
            int n;
            logic r, ss, lr;
            n  = int'($urandom_range(1, 10));
            r  = ($urandom_range(0, 39) == 0);
            ss = ($urandom_range(0, 2) == 0);
            lr = ($urandom_range(0, 1) == 0);
            if (r) n = 1;
            for (int c = 0; c < n; c++) begin
                step(r, ss, lr, 24'($urandom), 1, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
